// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one combinational magnitude
// comparator among N_REQ requesters, with a tagged response.
module cmp_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]       cmp_a,
  output logic [WIDTH-1:0]       cmp_b,
  input  logic                   cmp_G,
  input  logic                   cmp_E,
  input  logic                   cmp_L,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_G,
  output logic                   rsp_E,
  output logic                   rsp_L,
  output logic                   rsp_err,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  win_id;
  logic             win_found;
  logic             accept;
  logic             rsp_fire;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             code_bad;

  // Pick the valid requester closest after rr_ptr in cyclic order.
  always_comb begin
    int d;
    int best;
    win_id    = '0;
    win_found = |req_valid;
    best      = N_REQ;
    d         = 0;
    for (int i = 0; i < N_REQ; i++) begin
      d = (i - int'(rr_ptr) - 1 + 2 * N_REQ) % N_REQ;
      if (req_valid[i] && d < best) begin
        best   = d;
        win_id = ID_W'(i);
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_id == ID_W'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign accept   = (state == IDLE) && win_found;
  assign rsp_fire = (state == RESP) && rsp_valid && rsp_ready;

  // Exactly one of G/E/L must be set for a sane comparator code.
  assign code_bad = ~((cmp_G ^ cmp_E ^ cmp_L) &
                      ~(cmp_G & cmp_E & cmp_L));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready = '0;
    busy      = (state != IDLE);
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = accept && (win_id == ID_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= ID_W'(N_REQ - 1);
      cmp_a  <= '0;
      cmp_b  <= '0;
      rsp_id <= '0;
    end else if (accept) begin
      rr_ptr <= win_id;
      cmp_a  <= sel_a;
      cmp_b  <= sel_b;
      rsp_id <= win_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_G     <= 1'b0;
      rsp_E     <= 1'b0;
      rsp_L     <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (state == ISSUE) begin
      rsp_valid <= 1'b1;
      rsp_G     <= cmp_G;
      rsp_E     <= cmp_E;
      rsp_L     <= cmp_L;
      rsp_err   <= code_bad;
    end else if (rsp_fire) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
